// File: rtl/sr_reg_bank_if.sv
// Bus bundle for sr_reg_bank: per-channel enables, set/reset vectors, conflict clear
// and the registered state/debug outputs.
interface sr_reg_bank_if #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 8
);
    logic [CHANNELS-1:0]       en;
    logic [CHANNELS*WIDTH-1:0] s;
    logic [CHANNELS*WIDTH-1:0] r;
    logic                      clr_conflict;
    logic [CHANNELS*WIDTH-1:0] q;
    logic [CHANNELS*WIDTH-1:0] qbar;
    logic [CHANNELS-1:0]       conflict_ch;
    logic [CNT_W-1:0]          conflict_cnt;

    modport master (
        output en, s, r, clr_conflict,
        input  q, qbar, conflict_ch, conflict_cnt
    );

    modport slave (
        input  en, s, r, clr_conflict,
        output q, qbar, conflict_ch, conflict_cnt
    );
endinterface

// File: rtl/sr_reg_bank.sv
// Bank of CHANNELS x WIDTH clocked set/reset registers with deterministic s=r=1 handling,
// sticky conflict flags and a saturating conflict counter. Option: SR_REG_BANK_TOGGLE_EN (JK toggle on s=r=1).
module sr_reg_bank #(
    parameter int WIDTH       = 8,
    parameter int CHANNELS    = 4,
    parameter int SR_PRIORITY = 0,
    parameter int CNT_W       = 8
) (
    input  logic           clk,
    input  logic           rst,
    sr_reg_bank_if.slave   bus
);
    localparam int N = CHANNELS * WIDTH;

    logic [N-1:0]        q_q, q_d;
    logic [CHANNELS-1:0] conflict_ch_q, conflict_ch_d;
    logic [CNT_W-1:0]    conflict_cnt_q, conflict_cnt_d;
    logic [CHANNELS-1:0] event_mask;
    logic                any_event;

    function automatic logic [WIDTH-1:0] next_bits(input logic [WIDTH-1:0] qc,
                                                   input logic [WIDTH-1:0] sc,
                                                   input logic [WIDTH-1:0] rc);
        logic [WIDTH-1:0] both;
`ifdef SR_REG_BANK_TOGGLE_EN
        both = ~qc;
`else
        case (SR_PRIORITY)
            0:       both = '0;
            1:       both = '1;
            default: both = qc;
        endcase
`endif
        return (qc & ~sc & ~rc) | (sc & ~rc) | (sc & rc & both);
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    always_comb begin
        q_d        = q_q;
        event_mask = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (bus.en[c]) begin
                q_d[c*WIDTH +: WIDTH] = next_bits(q_q[c*WIDTH +: WIDTH],
                                                  bus.s[c*WIDTH +: WIDTH],
                                                  bus.r[c*WIDTH +: WIDTH]);
                event_mask[c] = |(bus.s[c*WIDTH +: WIDTH] & bus.r[c*WIDTH +: WIDTH]);
            end
        end
        any_event = |event_mask;
        // A conflict in the clearing cycle survives the clear.
        if (bus.clr_conflict) begin
            conflict_ch_d  = event_mask;
            conflict_cnt_d = any_event ? CNT_W'(1) : '0;
        end else begin
            conflict_ch_d  = conflict_ch_q | event_mask;
            conflict_cnt_d = any_event ? sat_inc(conflict_cnt_q) : conflict_cnt_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q            <= '0;
            conflict_ch_q  <= '0;
            conflict_cnt_q <= '0;
        end else begin
            q_q            <= q_d;
            conflict_ch_q  <= conflict_ch_d;
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    assign bus.q            = q_q;
    assign bus.qbar         = ~q_q;
    assign bus.conflict_ch  = conflict_ch_q;
    assign bus.conflict_cnt = conflict_cnt_q;
endmodule

// File: tb/tb_sr_reg_bank.sv
// Scoreboard bench for sr_reg_bank: three instances (reset-wins, set-wins, hold with CNT_W=2)
// share one random/directed stimulus stream and are compared against a bit-level reference model.
module tb_sr_reg_bank;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  en_t;
    logic [31:0] s_t, r_t;
    logic        clr_t;

    int checks   = 0;
    int failures = 0;

    sr_reg_bank_if #(.WIDTH(8), .CHANNELS(4), .CNT_W(8)) if0 ();
    sr_reg_bank_if #(.WIDTH(8), .CHANNELS(4), .CNT_W(8)) if1 ();
    sr_reg_bank_if #(.WIDTH(8), .CHANNELS(4), .CNT_W(2)) if2 ();

    assign if0.en = en_t; assign if0.s = s_t; assign if0.r = r_t; assign if0.clr_conflict = clr_t;
    assign if1.en = en_t; assign if1.s = s_t; assign if1.r = r_t; assign if1.clr_conflict = clr_t;
    assign if2.en = en_t; assign if2.s = s_t; assign if2.r = r_t; assign if2.clr_conflict = clr_t;

    sr_reg_bank #(.WIDTH(8), .CHANNELS(4), .SR_PRIORITY(0), .CNT_W(8)) dut0 (.clk(clk), .rst(rst), .bus(if0));
    sr_reg_bank #(.WIDTH(8), .CHANNELS(4), .SR_PRIORITY(1), .CNT_W(8)) dut1 (.clk(clk), .rst(rst), .bus(if1));
    sr_reg_bank #(.WIDTH(8), .CHANNELS(4), .SR_PRIORITY(2), .CNT_W(2)) dut2 (.clk(clk), .rst(rst), .bus(if2));

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0][31:0] q;
        logic [2:0][3:0]  ch;
        logic [2:0][7:0]  cnt;
    } exp_t;

    exp_t expq[$];

    // Reference state per instance
    logic [31:0] mq   [3];
    logic [3:0]  mch  [3];
    int          mcnt [3];
    int          cmax [3] = '{255, 255, 3};
    int          prio [3] = '{0, 1, 2};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int d = 0; d < 3; d++) begin
            mq[d] = '0; mch[d] = '0; mcnt[d] = 0;
        end
    endfunction

    function automatic void model_step(input logic [3:0] e, input logic [31:0] sv,
                                       input logic [31:0] rv, input logic clr);
        logic [3:0] ev;
        bit         any;
        ev = '0;
        for (int c = 0; c < 4; c++)
            for (int b = 0; b < 8; b++)
                if (e[c] && sv[c*8+b] && rv[c*8+b]) ev[c] = 1'b1;
        any = (ev != 0);
        for (int d = 0; d < 3; d++) begin
            for (int c = 0; c < 4; c++) begin
                if (!e[c]) continue;
                for (int b = 0; b < 8; b++) begin
                    int i;
                    i = c*8 + b;
                    if (sv[i] && !rv[i])      mq[d][i] = 1'b1;
                    else if (!sv[i] && rv[i]) mq[d][i] = 1'b0;
                    else if (sv[i] && rv[i]) begin
`ifdef SR_REG_BANK_TOGGLE_EN
                        mq[d][i] = ~mq[d][i];
`else
                        if (prio[d] == 0)      mq[d][i] = 1'b0;
                        else if (prio[d] == 1) mq[d][i] = 1'b1;
`endif
                    end
                end
            end
            if (clr) begin
                mch[d]  = ev;
                mcnt[d] = any ? 1 : 0;
            end else begin
                mch[d] = mch[d] | ev;
                if (any && mcnt[d] < cmax[d]) mcnt[d] = mcnt[d] + 1;
            end
        end
    endfunction

    task automatic drive(input logic [3:0] e, input logic [31:0] sv, input logic [31:0] rv, input logic c);
        exp_t x;
        @(negedge clk);
        en_t = e; s_t = sv; r_t = rv; clr_t = c;
        model_step(e, sv, rv, c);
        for (int d = 0; d < 3; d++) begin
            x.q[d]   = mq[d];
            x.ch[d]  = mch[d];
            x.cnt[d] = mcnt[d][7:0];
        end
        expq.push_back(x);
    endtask

    task automatic idle();
        drive(4'h0, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (expq.size() > 0 && n < 20) begin
            @(posedge clk);
            n++;
        end
        #2;
        checks++;
        if (expq.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout actual=%0d expected=0 pending entries", expq.size());
            expq.delete();
        end
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_q0"},    if0.q, 32'h0);
        chk({tag, "_qbar0"}, if0.qbar, 32'hFFFF_FFFF);
        chk({tag, "_ch0"},   {28'h0, if0.conflict_ch}, 32'h0);
        chk({tag, "_cnt0"},  {24'h0, if0.conflict_cnt}, 32'h0);
        chk({tag, "_q1"},    if1.q, 32'h0);
        chk({tag, "_cnt1"},  {24'h0, if1.conflict_cnt}, 32'h0);
        chk({tag, "_q2"},    if2.q, 32'h0);
        chk({tag, "_qbar2"}, if2.qbar, 32'hFFFF_FFFF);
        chk({tag, "_cnt2"},  {30'h0, if2.conflict_cnt}, 32'h0);
    endtask

    // Monitor: every edge the DUTs update, compare against the oldest expectation
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (!rst && expq.size() > 0) begin
                x = expq.pop_front();
                chk("q_prio0",    if0.q, x.q[0]);
                chk("qbar_prio0", if0.qbar, ~x.q[0]);
                chk("ch_prio0",   {28'h0, if0.conflict_ch}, {28'h0, x.ch[0]});
                chk("cnt_prio0",  {24'h0, if0.conflict_cnt}, {24'h0, x.cnt[0]});
                chk("q_prio1",    if1.q, x.q[1]);
                chk("qbar_prio1", if1.qbar, ~x.q[1]);
                chk("ch_prio1",   {28'h0, if1.conflict_ch}, {28'h0, x.ch[1]});
                chk("cnt_prio1",  {24'h0, if1.conflict_cnt}, {24'h0, x.cnt[1]});
                chk("q_prio2",    if2.q, x.q[2]);
                chk("qbar_prio2", if2.qbar, ~x.q[2]);
                chk("ch_prio2",   {28'h0, if2.conflict_ch}, {28'h0, x.ch[2]});
                chk("cnt_cntw2",  {30'h0, if2.conflict_cnt}, {24'h0, x.cnt[2]});
            end
        end
    end

    initial begin
        rst = 1'b1; en_t = '0; s_t = '0; r_t = '0; clr_t = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        check_reset_state("init");
        @(negedge clk);
        rst = 1'b0;

        // Set / reset / hold on channel 0
        drive(4'b0001, 32'h0000_00A5, 32'h0, 1'b0);
        drive(4'b0001, 32'h0,         32'h0000_0005, 1'b0);
        drive(4'b0000, 32'h0000_00FF, 32'h0, 1'b0);
        // Conflict resolution from q=0x0F
        drive(4'b0001, 32'h0000_000F, 32'h0000_00F0, 1'b0);
        drive(4'b0001, 32'h0000_00FF, 32'h0000_00FF, 1'b0);
        // Flags and counter
        drive(4'b0000, 32'h0, 32'h0, 1'b1);
        repeat (3) drive(4'b1010, 32'h0100_0100, 32'h0100_0100, 1'b0);
        repeat (3) drive(4'b0000, 32'h0100_0100, 32'h0100_0100, 1'b0);
        // Push the 2-bit counter past saturation
        repeat (2) drive(4'b1111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        drive(4'b0000, 32'h0, 32'h0, 1'b1);
        drive(4'b1111, 32'h00FF_0000, 32'h00FF_0000, 1'b1);
        idle();
        drain();

        // Asynchronous reset mid-cycle with channel 0 at 0xFF
        drive(4'b0001, 32'h0000_00FF, 32'h0, 1'b0);
        drive(4'b0010, 32'h0000_0100, 32'h0000_0100, 1'b0);
        idle();
        drain();
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check_reset_state("async_rst");
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic [31:0] sv, rv;
            sv = $urandom;
            rv = $urandom & $urandom;
            drive(4'($urandom), sv, rv, ($urandom_range(0, 7) == 0));
        end
        idle();
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=%0t expected=finish", $time);
        $fatal(1, "bench timeout");
    end
endmodule

// File: doc/sr_reg_bank.md
Name: sr_reg_bank

Overview:
- Clocked, parametrised successor to the single gated SR latch: CHANNELS independent WIDTH-bit set/reset registers, each with its own enable.
- The forbidden S=R=1 case is resolved deterministically by a parameter instead of being left undefined.
- Per-channel sticky conflict flags and a saturating conflict-cycle counter are provided for debug.
- Sits between control decode and status/flag consumers as the team's generic multi-bit flag store.

Parameters:
- WIDTH, 8, bits per channel (>=1)
- CHANNELS, 4, number of independent channels (>=1)
- SR_PRIORITY, 0, resolution of s=r=1 per bit: 0 = reset wins, 1 = set wins, 2 = hold
- CNT_W, 8, width of conflict_cnt (>=2)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- en  input  CHANNELS  per-channel update enable; bit c gates channel c
- s  input  CHANNELS*WIDTH  set vector; channel c occupies bits [c*WIDTH +: WIDTH]
- r  input  CHANNELS*WIDTH  reset vector, same packing as s
- clr_conflict  input  1  synchronous clear of conflict_ch and conflict_cnt
- q  output  CHANNELS*WIDTH  registered state, same packing
- qbar  output  CHANNELS*WIDTH  bitwise complement of q, always
- conflict_ch  output  CHANNELS  sticky per-channel flag: an enabled s=r=1 bit has occurred
- conflict_cnt  output  CNT_W  count of cycles with at least one enabled conflict, saturating

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset state (immediate on rst=1, held while asserted): q=0, qbar=all ones, conflict_ch=0, conflict_cnt=0.
- Update latency: one clock. q reflects inputs sampled at the same rising edge; no combinational path from s/r/en to q/qbar.
- Per bit, when en[c]=1:
  - s=1, r=0 -> q=1
  - s=0, r=1 -> q=0
  - s=0, r=0 -> hold
  - s=1, r=1 -> resolved per SR_PRIORITY
- When en[c]=0: channel c holds regardless of s/r, and its bits never count as conflicts.
- qbar is derived from q only; q==qbar never occurs, including during reset.
- Conflict event, channel c: en[c]=1 and (s_c & r_c) != 0 at a rising edge.
  - Sets conflict_ch[c]=1 (sticky).
- Counter:
  - conflict_cnt increments by 1 per edge at which any channel has a conflict event, independent of how many bits or channels conflict.
  - Saturates at 2^CNT_W-1; no wrap.
- clr_conflict=1 at an edge:
  - conflict_ch becomes the current cycle's conflict-event mask.
  - conflict_cnt becomes 1 if any event occurs that cycle, else 0.
  - A new event therefore wins over clear.
- clr_conflict has no effect on q.
- Reset mid-operation: all state returns to reset values asynchronously. First update happens at the first rising edge after rst deasserts.
- Channels are fully independent; simultaneous enables on all channels are legal.

Optional Feature:
- Macro: SR_REG_BANK_TOGGLE_EN
- Defined: s=r=1 on an enabled bit toggles q (JK semantics), overriding SR_PRIORITY. These cycles are still counted as conflicts and still set conflict_ch.
- Undefined: SR_PRIORITY resolution applies as above; no toggle logic is synthesised.

Test Plan:
- Reset: assert rst mid-cycle with q=0xFF on channel 0 -> q=0x00, qbar=0xFF, conflict_cnt=0 without waiting for a clock edge.
- Set/reset/hold (defaults):
  - en=4'b0001, s[7:0]=0xA5, r=0 -> q[7:0]=0xA5 after one edge, other channels 0.
  - Then s=0, r[7:0]=0x05 -> q[7:0]=0xA0.
  - Then en=0, s=0xFF -> q[7:0] stays 0xA0.
- Conflict resolution:
  - SR_PRIORITY=0, q[7:0]=0x0F, s=r=0xFF -> q=0x00.
  - SR_PRIORITY=1, same stimulus -> q=0xFF.
  - SR_PRIORITY=2, same stimulus -> q=0x0F.
  - With SR_REG_BANK_TOGGLE_EN -> q=0xF0.
- Flags and counter:
  - s=r=0x01 on channels 1 and 3 with en=4'b1010 for 3 cycles -> conflict_ch=4'b1010, conflict_cnt=3.
  - Same stimulus with en=0 -> no change.
- Saturation and clear:
  - CNT_W=2, 5 conflict cycles -> conflict_cnt=3.
  - clr_conflict with no conflict -> 0, conflict_ch=0.
  - clr_conflict coincident with a channel-2 conflict -> conflict_cnt=1, conflict_ch=4'b0100.
